// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle datapath memory port. It accepts one
// outstanding word read or write. The request is captured in IDLE. The block
// then waits WAIT_CYCLES states and completes the access in RESP against an
// internal word-organised RAM. RESP lasts one cycle and is flagged by MemReady.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 4..4096)
//   WAIT_CYCLES  wait states between acceptance and completion (0..15)
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   synchronous active-high reset
//   MemRead    in   read request strobe (sampled only in IDLE)
//   MemWrite   in   write request strobe (sampled only in IDLE)
//   Address    in   32-bit byte address
//   WriteData  in   32-bit store data, captured with the request
//   ReadData   out  registered read data, updated only by a legal read
//   MemReady   out  one-cycle completion pulse (RESP state)
//   MemError   out  completed request was illegal (only with MemReady)
//   Busy       out  high in WAIT and RESP
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        Busy
);

    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_CYCLES);
    localparam bit         DIRECT_RESP = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  count_r;
    logic [3:0]  count_next_s;

    // Captured request
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        rd_r;
    logic        wr_r;
    logic        err_r;

    // Effective request: the live inputs while IDLE, the captured copy after.
    // With zero wait states the access completes on the acceptance edge.
    // In that case the captured copy does not exist yet.
    logic [31:0] req_addr_s;
    logic [31:0] req_wdata_s;
    logic        req_rd_s;
    logic        req_wr_s;

    logic        accept_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic        conflict_s;
    logic        illegal_s;
    logic        enter_resp_s;
    logic        commit_rd_s;
    logic        commit_wr_s;
    logic [IDX_W-1:0] idx_s;

    logic [31:0] mem_r [DEPTH];

    // Select between live inputs and the captured request
    always_comb begin
        req_addr_s  = addr_r;
        req_wdata_s = wdata_r;
        req_rd_s    = rd_r;
        req_wr_s    = wr_r;
        if (state_r == ST_IDLE) begin
            req_addr_s  = Address;
            req_wdata_s = WriteData;
            req_rd_s    = MemRead;
            req_wr_s    = MemWrite;
        end else begin
            req_addr_s  = addr_r;
            req_wdata_s = wdata_r;
            req_rd_s    = rd_r;
            req_wr_s    = wr_r;
        end
    end

    // Legality of the effective request and the RAM word index
    always_comb begin
        accept_s       = (state_r == ST_IDLE) && (MemRead || MemWrite);
        misaligned_s   = (req_addr_s[1:0] != 2'b00);
        // Any set bit above the word index means the address is >= 4*DEPTH.
        out_of_range_s = |req_addr_s[31:IDX_W+2];
        conflict_s     = req_rd_s && req_wr_s;
        illegal_s      = misaligned_s || out_of_range_s || conflict_s;
        idx_s          = req_addr_s[IDX_W+1:2];
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    count_next_s = WAIT_LOAD;
                    if (DIRECT_RESP) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A count of 0 here cannot occur. Treating it like 1 means WAIT
                // always exits.
                if (count_r <= 4'd1) begin
                    state_next_s = ST_RESP;
                    count_next_s = 4'd0;
                end else begin
                    state_next_s = ST_WAIT;
                    count_next_s = count_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
                count_next_s = 4'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = 4'd0;
            end
        endcase
    end

    // Commit strobes for the edge that enters RESP; reset cancels both
    always_comb begin
        enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP);
        commit_rd_s  = enter_resp_s && req_rd_s && !illegal_s && !Reset;
        commit_wr_s  = enter_resp_s && req_wr_s && !illegal_s && !Reset;
    end

    // State register and wait counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Request capture on acceptance
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= Address;
            wdata_r <= WriteData;
            rd_r    <= MemRead;
            wr_r    <= MemWrite;
        end
    end

    // Error flag latched on RESP entry so MemError comes from a register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_r <= 1'b0;
        end else if (enter_resp_s) begin
            err_r <= illegal_s;
        end
    end

    // Read data register, loaded only by a legal read
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ReadData <= 32'd0;
        end else if (commit_rd_s) begin
            ReadData <= mem_r[idx_s];
        end
    end

    // Word RAM write port. Reset does not clear the contents.
    always_ff @(posedge Clk) begin
        if (commit_wr_s) begin
            mem_r[idx_s] <= req_wdata_s;
        end
    end

    // Output decode from the registered state
    always_comb begin
        MemReady = 1'b0;
        MemError = 1'b0;
        Busy     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                MemReady = 1'b0;
                MemError = 1'b0;
                Busy     = 1'b0;
            end
            ST_WAIT: begin
                MemReady = 1'b0;
                MemError = 1'b0;
                Busy     = 1'b1;
            end
            ST_RESP: begin
                MemReady = 1'b1;
                MemError = err_r;
                Busy     = 1'b1;
            end
            default: begin
                MemReady = 1'b0;
                MemError = 1'b0;
                Busy     = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle datapath's memory port. It accepts a single outstanding read or write request driven by the control unit's MemRead/MemWrite strobes. After a programmable number of wait states it completes the request against an internal word-organized RAM and returns read data with a one-cycle completion pulse. It sits opposite the processor's IorD address mux and feeds the instruction register and memory data register paths.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 2: wait states inserted between acceptance and completion; 0..15.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset; one clock, synchronous reset.
- MemRead  in  1  read request strobe.
- MemWrite  in  1  write request strobe.
- Address  in  32  byte address from the IorD mux.
- WriteData  in  32  store data; captured with the request.
- ReadData  out  32  registered read data; holds until the next successful read completes.
- MemReady  out  1  one-cycle completion pulse.
- MemError  out  1  asserted only together with MemReady when the completed request was illegal.
- Busy  out  1  high in WAIT and RESP states.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - MemRead or MemWrite high → accept. Capture Address, WriteData and the request type, load the wait counter with WAIT_CYCLES, and go to WAIT.
  - If WAIT_CYCLES=0, go directly to RESP.
- WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter is 1, so WAIT lasts exactly WAIT_CYCLES cycles.
- RESP: MemReady=1 for exactly this cycle, then unconditionally return to IDLE.
- Request legality is checked on the captured values:
  - Address[1:0]≠0 → misaligned.
  - Address ≥ 4·DEPTH → out of range.
  - MemRead and MemWrite both high → conflict.
  - Any of these: MemError=1 in RESP, no RAM write, ReadData unchanged.
- Legal read: ReadData ← RAM[Address[log2(DEPTH)+1:2]], updated on the edge entering RESP, so it is valid while MemReady=1.
- Legal write: RAM word written on the edge entering RESP; ReadData unchanged.
- Only full 32-bit word accesses are supported; there are no byte enables.
- Requests are sampled only in IDLE. Strobes in WAIT or RESP are ignored, including a strobe still held during the MemReady cycle.
- The requester holds its strobes and Address until MemReady; changes after acceptance have no effect.
- Reset:
  - State=IDLE, counter=0, ReadData=0, MemReady=0, MemError=0, Busy=0.
  - RAM contents are not cleared and are undefined until written.
  - Reset in WAIT aborts the request; a write that has not reached the RESP-entry edge is never committed.
  - Reset high in the same cycle as a strobe in IDLE: reset wins and the request is dropped.

## Timing
- Request first seen in IDLE in cycle N → MemReady=1 in cycle N+1+WAIT_CYCLES.
- Busy is high for cycles N+1 .. N+1+WAIT_CYCLES.
- Back-to-back: the earliest next accept is cycle N+2+WAIT_CYCLES (the first IDLE cycle), giving a throughput of one access per WAIT_CYCLES+2 cycles.
- The written word is readable by the next accepted read, with no forwarding needed.
- ReadData is a register output with no combinational path from inputs; MemReady, MemError and Busy decode from registered state only.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x10 with the request in cycle 0 → MemReady in cycle 3, MemError=0.
  - Read 0x10 starting cycle 4 → ReadData=0xDEADBEEF and MemReady in cycle 7.
- Illegal addresses, DEPTH=256:
  - Read 0x13 → MemReady with MemError=1, ReadData keeps its previous value.
  - Write to 0x400 → MemError=1, and a later read of 0x000 is unchanged.
- Conflict: MemRead=MemWrite=1 to 0x20 → MemError=1, and a following read of 0x20 returns its prior contents.
- Reset mid-operation: write 0x12345678 to 0x30, assert Reset in the first WAIT cycle → outputs 0 the next cycle, and a subsequent read of 0x30 does not return 0x12345678 (preload it with 0xA5A5A5A5 first and expect 0xA5A5A5A5).
- WAIT_CYCLES=0 streaming:
  - Hold MemRead continuously on 0x0, 0x4 and 0x8 (pre-written 1, 2, 3) → MemReady pulses every 2nd cycle with ReadData 1, 2, 3.
  - A strobe held during a MemReady cycle does not create an extra pulse.
- Strobe in WAIT changes Address from 0x40 to 0x44 → the completion uses 0x40.
